ccip_c0_rd_sched: RTL

- Round-robin scheduler sharing the CCI-P c0 read-request channel among NUM_REQ AFU requesters.
- Throttles issue so that lines in flight never exceed MAX_ACTIVE_LINES (sized from the platform's C0 max-bandwidth active-line count for the default VC).
- Honors c0 almost-full and returns credits from read responses.
- Steers each response back to its requester using an ID field in mdata.
- Provides a drain handshake for clean soft-reset / reconfiguration.

---
 rtl/ccip_c0_rd_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ccip_c0_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : ccip_c0_rd_sched
// Purpose  : Round-robin scheduler for the CCI-P c0 read-request channel with
//            line-credit throttling, response steering and drain handshake.
//            Define CCIP_C0_RD_SCHED_STATS_EN to add grant/throttle counters.
// Revision : 1.0
// ============================================================================
module ccip_c0_rd_sched #(
    parameter int          NUM_REQ          = 4,
    parameter int          MAX_ACTIVE_LINES = 512,
    parameter logic [1:0]  VC_SEL           = 2'd0,
    parameter logic [3:0]  CL_LEN_MASK      = 4'b1011,
    localparam int         CW               = $clog2(MAX_ACTIVE_LINES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*42-1:0]   req_addr,
    input  logic [NUM_REQ*2-1:0]    req_len,
    input  logic [NUM_REQ*13-1:0]   req_tag,
    output logic                    c0tx_valid,
    output logic [41:0]             c0tx_addr,
    output logic [1:0]              c0tx_len,
    output logic [1:0]              c0tx_vc,
    output logic [15:0]             c0tx_mdata,
    input  logic                    c0_alm_full,
    input  logic                    c0rx_valid,
    input  logic [15:0]             c0rx_mdata,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [12:0]             rsp_tag,
    input  logic                    drain_req,
    output logic                    drained,
    output logic [CW-1:0]           active_lines
`ifdef CCIP_C0_RD_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]   stat_grants,
    output logic [31:0]             stat_throttle
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_ptr;
    logic [CW-1:0]       r_active;

    logic [1:0]          w_len_eff [NUM_REQ];
    logic [2:0]          w_lines   [NUM_REQ];
    logic [NUM_REQ-1:0]  w_elig;
    logic                w_grant;
    logic [PW-1:0]       w_gidx;
    logic [CW:0]         w_active_sum;
    logic [CW:0]         w_active_nxt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [1:0] w_len_in;
        assign w_len_in       = req_len[gi*2 +: 2];
        assign w_len_eff[gi]  = ((w_len_in == 2'd2) || !CL_LEN_MASK[w_len_in]) ? 2'd0 : w_len_in;
        assign w_lines[gi]    = (w_len_eff[gi] == 2'd3) ? 3'd4 : ({1'b0, w_len_eff[gi]} + 3'd1);
        // Reset gates eligibility so no grant is visible while reset is held.
        assign w_elig[gi]     = req_valid[gi] && !reset && (r_state == S_RUN) && !c0_alm_full &&
                                (({1'b0, r_active} + (CW+1)'(w_lines[gi])) <= (CW+1)'(MAX_ACTIVE_LINES));
        assign req_ready[gi]  = w_grant && (w_gidx == PW'(gi));
        assign rsp_valid[gi]  = c0rx_valid && (c0rx_mdata[15:13] == 3'(gi));
    end

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant && w_elig[rr_index(r_ptr, k)]) begin
                w_grant = 1'b1;
                w_gidx  = rr_index(r_ptr, k);
            end
        end
    end

    // Credits are added before the response is retired, so a response at zero
    // only saturates when nothing is granted in the same cycle.
    always_comb begin
        w_active_sum = {1'b0, r_active} + (w_grant ? (CW+1)'(w_lines[w_gidx]) : '0);
        w_active_nxt = w_active_sum;
        if (c0rx_valid && (w_active_sum != '0))
            w_active_nxt = w_active_sum - (CW+1)'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        drained     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (drain_req) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                drained = (r_active == '0);
                if (!drain_req) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_ptr      <= '0;
            r_active   <= '0;
            c0tx_valid <= 1'b0;
            c0tx_addr  <= '0;
            c0tx_len   <= '0;
            c0tx_vc    <= '0;
            c0tx_mdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_active   <= w_active_nxt[CW-1:0];
            c0tx_valid <= w_grant;
            if (w_grant) begin
                r_ptr      <= (w_gidx == PW'(NUM_REQ-1)) ? '0 : (w_gidx + PW'(1));
                c0tx_addr  <= req_addr[w_gidx*42 +: 42];
                c0tx_len   <= w_len_eff[w_gidx];
                c0tx_vc    <= VC_SEL;
                c0tx_mdata <= {3'(w_gidx), req_tag[w_gidx*13 +: 13]};
            end
        end
    end

    assign active_lines = r_active;
    assign rsp_tag      = c0rx_mdata[12:0];

`ifdef CCIP_C0_RD_SCHED_STATS_EN
    logic [31:0] r_stat_grants [NUM_REQ];
    logic [31:0] r_stat_throttle;

    for (genvar gs = 0; gs < NUM_REQ; gs++) begin : g_stat
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                r_stat_grants[gs] <= '0;
            else if (req_ready[gs])
                r_stat_grants[gs] <= r_stat_grants[gs] + 32'd1;
        end
        assign stat_grants[gs*32 +: 32] = r_stat_grants[gs];
    end

    // In RUN, a valid request without a grant can only be held off by
    // almost-full or by the line credit limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stat_throttle <= '0;
        else if ((r_state == S_RUN) && (|req_valid) && !w_grant)
            r_stat_throttle <= r_stat_throttle + 32'd1;
    end
    assign stat_throttle = r_stat_throttle;
`endif

endmodule
`default_nettype wire
